// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic matrix engine.
// FSM encoding lives here so the top and any future tooling agree on it.
package systolic_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int DEF_BITS_AB  = 8;
    localparam int DEF_BITS_C   = 16;
    localparam int DEF_DIM      = 8;
    localparam int DEF_SATURATE = 0;

endpackage

// File: rtl/mac_pe.sv
// Output-stationary multiply-accumulate cell with registered A/B pass-through.
// Accumulator either wraps or clamps depending on SATURATE.
module mac_pe
    import systolic_pkg::*;
#(
    parameter int BITS_AB  = DEF_BITS_AB,
    parameter int BITS_C   = DEF_BITS_C,
    parameter int SATURATE = DEF_SATURATE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      step,
    input  logic                      clear,
    input  logic signed [BITS_AB-1:0] a_in,
    input  logic signed [BITS_AB-1:0] b_in,
    output logic signed [BITS_AB-1:0] a_out,
    output logic signed [BITS_AB-1:0] b_out,
    output logic signed [BITS_C-1:0]  acc
);

    localparam logic signed [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
    localparam logic signed [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

    logic signed [2*BITS_AB-1:0] prod;
    logic signed [BITS_C:0]      sum;
    logic signed [BITS_C-1:0]    acc_nx;

    assign prod = a_in * b_in;
    assign sum  = (BITS_C+1)'(acc) + (BITS_C+1)'(prod);

    // One guard bit is enough: a single add can only overflow by one bit.
    always_comb begin
        acc_nx = sum[BITS_C-1:0];
        if (SATURATE != 0 && sum[BITS_C] != sum[BITS_C-1])
            acc_nx = sum[BITS_C] ? C_MIN : C_MAX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (clear) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (step) begin
            acc   <= acc_nx;
            a_out <= a_in;
            b_out <= b_in;
        end
    end

endmodule

// File: rtl/systolic_engine.sv
// DIM x DIM output-stationary systolic matrix multiplier with internal
// input skewing, beat/drain sequencing and a row read port for C.
module systolic_engine
    import systolic_pkg::*;
#(
    parameter int BITS_AB  = DEF_BITS_AB,
    parameter int BITS_C   = DEF_BITS_C,
    parameter int DIM      = DEF_DIM,
    parameter int SATURATE = DEF_SATURATE
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               accumulate,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [DIM-1:0][BITS_AB-1:0] a_col,
    input  logic signed [DIM-1:0][BITS_AB-1:0] b_row,
    output logic                               busy,
    output logic                               done,
    input  logic                               rd_en,
    input  logic [$clog2(DIM)-1:0]             rd_row,
    output logic signed [DIM-1:0][BITS_C-1:0]  rd_data,
    output logic                               rd_valid
);

    localparam int CW = $clog2(2*DIM);
    localparam int RW = $clog2(DIM);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          step, clear, last_beat, last_drain, rd_go, row_ok;

    logic signed [BITS_AB-1:0] a_h [DIM][DIM+1];
    logic signed [BITS_AB-1:0] b_v [DIM+1][DIM];
    logic signed [BITS_C-1:0]  acc [DIM][DIM];

    assign step       = (state == S_LOAD && in_valid) || state == S_DRAIN;
    assign clear      = state == S_IDLE && start && !accumulate;
    assign last_beat  = cnt == CW'(DIM-1);
    assign last_drain = cnt == CW'(2*DIM-3);
    assign rd_go      = state == S_IDLE && rd_en;
    assign row_ok     = {1'b0, rd_row} < (RW+1)'(DIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nx = S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last_beat) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (last_drain) state_nx = S_DONE;
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Counts accepted beats in LOAD, then drain cycles; restarts per state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cnt <= '0;
        else if (state != state_nx) cnt <= '0;
        else if (step)              cnt <= cnt + 1'b1;
    end

    for (genvar i = 0; i < DIM; i++) begin : g_skew
        logic signed [BITS_AB-1:0] a_src, b_src;
        assign a_src = (state == S_LOAD) ? a_col[i] : '0;
        assign b_src = (state == S_LOAD) ? b_row[i] : '0;
        if (i == 0) begin : g_direct
            assign a_h[0][0] = a_src;
            assign b_v[0][0] = b_src;
        end else begin : g_delay
            logic signed [BITS_AB-1:0] sa [i];
            logic signed [BITS_AB-1:0] sb [i];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) begin
                        sa[k] <= '0;
                        sb[k] <= '0;
                    end
                end else if (step) begin
                    sa[0] <= a_src;
                    sb[0] <= b_src;
                    for (int k = 1; k < i; k++) begin
                        sa[k] <= sa[k-1];
                        sb[k] <= sb[k-1];
                    end
                end
            end
            assign a_h[i][0] = sa[i-1];
            assign b_v[0][i] = sb[i-1];
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_row
        for (genvar j = 0; j < DIM; j++) begin : g_col
            mac_pe #(
                .BITS_AB (BITS_AB),
                .BITS_C  (BITS_C),
                .SATURATE(SATURATE)
            ) u_pe (
                .clk  (clk),
                .rst  (rst),
                .step (step),
                .clear(clear),
                .a_in (a_h[i][j]),
                .b_in (b_v[i][j]),
                .a_out(a_h[i][j+1]),
                .b_out(b_v[i+1][j]),
                .acc  (acc[i][j])
            );
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_go;
            if (rd_go) begin
                for (int j = 0; j < DIM; j++)
                    rd_data[j] <= row_ok ? acc[rd_row][j] : '0;
            end
        end
    end

endmodule

// File: tb/tb_systolic_engine.sv
// Directed bench for systolic_engine at DIM=4: wrap and saturate
// instances share stimulus and are checked against hand-derived values.
module tb_systolic_engine;
    import systolic_pkg::*;

    localparam int DIM = 4;
    localparam int AB  = 8;
    localparam int CB  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic accumulate = 1'b0;
    logic in_valid = 1'b0;
    logic rd_en = 1'b0;
    logic [1:0] rd_row = '0;
    logic signed [DIM-1:0][AB-1:0] a_col = '0;
    logic signed [DIM-1:0][AB-1:0] b_row = '0;

    logic in_ready_w, busy_w, done_w, rd_valid_w;
    logic in_ready_s, busy_s, done_s, rd_valid_s;
    logic signed [DIM-1:0][CB-1:0] rd_data_w, rd_data_s;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ma [DIM][DIM];
    int mb [DIM][DIM];

    always #5 clk = ~clk;

    systolic_engine #(.BITS_AB(AB), .BITS_C(CB), .DIM(DIM), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .in_valid(in_valid), .in_ready(in_ready_w),
        .a_col(a_col), .b_row(b_row),
        .busy(busy_w), .done(done_w),
        .rd_en(rd_en), .rd_row(rd_row),
        .rd_data(rd_data_w), .rd_valid(rd_valid_w)
    );

    systolic_engine #(.BITS_AB(AB), .BITS_C(CB), .DIM(DIM), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .a_col(a_col), .b_row(b_row),
        .busy(busy_s), .done(done_s),
        .rd_en(rd_en), .rd_row(rd_row),
        .rd_data(rd_data_s), .rd_valid(rd_valid_s)
    );

    function automatic logic [31:0] h16(input int x);
        logic [15:0] t;
        t = 16'(x);
        return {16'd0, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_identity();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = 4*i + j;
            end
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < DIM; i++) begin
            a_col[i] = AB'(ma[i][k]);
            b_row[i] = AB'(mb[k][i]);
        end
    endtask

    task automatic read_row(input int r);
        rd_en = 1'b1;
        rd_row = 2'(r);
        tick();
        rd_en = 1'b0;
        chk($sformatf("rdv_w r%0d", r), 32'(rd_valid_w), 32'(1));
        chk($sformatf("rdv_s r%0d", r), 32'(rd_valid_s), 32'(1));
    endtask

    task automatic run_job(input bit acc_mode, input int gap, input bit poke, input int exp_done);
        bit seen;
        int waited;
        start = 1'b1;
        accumulate = acc_mode;
        cyc = 0;
        tick();
        start = 1'b0;
        accumulate = 1'b0;
        chk("load_ready", 32'(in_ready_w), 32'(1));
        for (int k = 0; k < DIM; k++) begin
            drive_beat(k);
            in_valid = 1'b1;
            tick();
            if (k == 0 && gap > 0) begin
                in_valid = 1'b0;
                a_col = '1;
                b_row = '1;
                repeat (gap) tick();
                chk("stall_ready", 32'(in_ready_w), 32'(1));
                chk("stall_busy", 32'(busy_s), 32'(1));
            end
        end
        in_valid = 1'b0;
        a_col = '0;
        b_row = '0;
        seen = 1'b0;
        waited = 0;
        while (waited < 40 && !seen) begin
            if (done_w) begin
                seen = 1'b1;
            end else begin
                if (poke && cyc == 6) begin
                    start = 1'b1;
                    rd_en = 1'b1;
                    rd_row = 2'd0;
                end
                tick();
                waited++;
                if (poke && cyc == 7) begin
                    chk("drain_rdv_w", 32'(rd_valid_w), 32'(0));
                    chk("drain_rdv_s", 32'(rd_valid_s), 32'(0));
                    chk("drain_hold", {16'd0, rd_data_w[0]}, h16(12));
                    start = 1'b0;
                    rd_en = 1'b0;
                end
            end
        end
        chk("done_seen", 32'(seen), 32'(1));
        chk("done_cyc", 32'(cyc), 32'(exp_done));
        chk("done_sat", 32'(done_s), 32'(1));
        tick();
        chk("idle_busy", 32'(busy_w), 32'(0));
        if (poke) begin
            tick();
            chk("no_restart", 32'(busy_w), 32'(0));
            chk("no_restart_rdy", 32'(in_ready_s), 32'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        chk("rst_ready", 32'(in_ready_w), 32'(0));
        chk("rst_busy", 32'(busy_w), 32'(0));
        chk("rst_done", 32'(done_s), 32'(0));
        chk("rst_rdv", 32'(rd_valid_w), 32'(0));
        rst = 1'b0;
        tick();
        chk("post_ready", 32'(in_ready_s), 32'(0));
        chk("post_busy", 32'(busy_s), 32'(0));
        chk("post_done", 32'(done_w), 32'(0));
        chk("post_rdv", 32'(rd_valid_s), 32'(0));
        chk("post_data", {16'd0, rd_data_w[2]}, h16(0));

        set_identity();
        run_job(1'b0, 0, 1'b0, 11);
        for (int r = 0; r < DIM; r++) begin
            read_row(r);
            for (int j = 0; j < DIM; j++) begin
                chk($sformatf("ident_w r%0d c%0d", r, j), {16'd0, rd_data_w[j]}, h16(4*r + j));
                chk($sformatf("ident_s r%0d c%0d", r, j), {16'd0, rd_data_s[j]}, h16(4*r + j));
            end
        end

        run_job(1'b1, 0, 1'b0, 11);
        for (int r = 0; r < DIM; r++) begin
            read_row(r);
            for (int j = 0; j < DIM; j++) begin
                chk($sformatf("accum_w r%0d c%0d", r, j), {16'd0, rd_data_w[j]}, h16(2*(4*r + j)));
                chk($sformatf("accum_s r%0d c%0d", r, j), {16'd0, rd_data_s[j]}, h16(2*(4*r + j)));
            end
        end

        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = 127;
                mb[i][j] = 127;
            end
        run_job(1'b0, 0, 1'b0, 11);
        for (int r = 0; r < DIM; r++) begin
            read_row(r);
            for (int j = 0; j < DIM; j++) begin
                chk($sformatf("big_w r%0d c%0d", r, j), {16'd0, rd_data_w[j]}, h16(-1020));
                chk($sformatf("big_s r%0d c%0d", r, j), {16'd0, rd_data_s[j]}, h16(32767));
            end
        end

        set_identity();
        run_job(1'b0, 3, 1'b0, 14);
        for (int r = 0; r < DIM; r++) begin
            read_row(r);
            for (int j = 0; j < DIM; j++) begin
                chk($sformatf("gap_w r%0d c%0d", r, j), {16'd0, rd_data_w[j]}, h16(4*r + j));
                chk($sformatf("gap_s r%0d c%0d", r, j), {16'd0, rd_data_s[j]}, h16(4*r + j));
            end
        end

        run_job(1'b0, 0, 1'b1, 11);
        read_row(1);
        for (int j = 0; j < DIM; j++)
            chk($sformatf("poke_w c%0d", j), {16'd0, rd_data_w[j]}, h16(4 + j));

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_beat(k);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_busy_w", 32'(busy_w), 32'(0));
        chk("midrst_busy_s", 32'(busy_s), 32'(0));
        chk("midrst_ready", 32'(in_ready_w), 32'(0));
        rst = 1'b0;
        tick();
        for (int r = 0; r < DIM; r++) begin
            read_row(r);
            for (int j = 0; j < DIM; j++) begin
                chk($sformatf("zero_w r%0d c%0d", r, j), {16'd0, rd_data_w[j]}, h16(0));
                chk($sformatf("zero_s r%0d c%0d", r, j), {16'd0, rd_data_s[j]}, h16(0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_engine.md
SYSTOLIC_ENGINE -- requirements
Module: systolic_engine

Interface
REQ-001 SHALL have parameter BITS_AB, default 8: signed width of A/B elements.
REQ-002 SHALL have parameter BITS_C, default 16: signed width of C accumulators.
REQ-003 SHALL have parameter DIM, default 8: array is DIM x DIM, legal range DIM >= 2.
REQ-004 SHALL have parameter SATURATE, default 0: 1 = clamp accumulators, 0 = wrap.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: start  in  1  begin job (sampled in IDLE); accumulate  in  1  sampled with start, 1 = keep prior C.
REQ-007 SHALL have ports: in_valid  in  1  beat valid; in_ready  out  1  beat accepted when in_valid&&in_ready.
REQ-008 SHALL have ports: a_col  in  DIM x BITS_AB signed  column k of A; b_row  in  DIM x BITS_AB signed  row k of B.
REQ-009 SHALL have ports: busy  out  1  job in progress; done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports: rd_en  in  1  read request; rd_row  in  $clog2(DIM)  C row index; rd_data  out  DIM x BITS_C signed; rd_valid  out  1.

Function
REQ-011 SHALL compute C = A x B (or C += A x B) from exactly DIM accepted beats, beat k carrying A[*][k] and B[k][*].
REQ-012 SHALL implement FSM IDLE -> LOAD (start) -> DRAIN (DIM-th beat accepted) -> DONE (drain count 2*DIM-2 reached) -> IDLE (unconditional, 1 cycle).
REQ-013 SHALL assert in_ready only in LOAD; busy in LOAD, DRAIN and DONE; done only in DONE.
REQ-014 SHALL skew inputs internally: A lane i and B lane j delayed by i and j array steps respectively, no external skewing.
REQ-015 SHALL advance array and skew registers only on a step: accepted beat in LOAD, or every DRAIN cycle (zeros injected).
REQ-016 SHALL hold all array state unchanged on LOAD cycles with in_valid low (stall); results identical to an unstalled run.
REQ-017 SHALL clear all DIM x DIM accumulators on the start cycle when accumulate=0; preserve them when accumulate=1.
REQ-018 SHALL form each product at 2*BITS_AB bits signed, sign-extend to BITS_C+1 for the add.
REQ-019 SHALL, with SATURATE=1, clamp each sum to [-2^(BITS_C-1), 2^(BITS_C-1)-1]; with SATURATE=0, wrap modulo 2^BITS_C.
REQ-020 SHALL, on rd_en in IDLE, present C[rd_row] on rd_data with rd_valid high on the next cycle.
REQ-021 SHALL ignore rd_en while busy (rd_valid 0, rd_data holds) and return all-zero rd_data for rd_row >= DIM.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL leave latency, unstalled, start at cycle 0: LOAD cycles 1..DIM, DRAIN DIM+1..3*DIM-2, done at cycle 3*DIM-1.

Reset
REQ-024 SHALL, on rst at any time incl. mid-job, force FSM IDLE and zero all accumulators, skew registers, counters, rd_data.
REQ-025 SHALL drive in_ready, busy, done, rd_valid to 0 during and immediately after reset.

Structure
REQ-026 SHALL place FSM state enum and default parameter constants in shared package systolic_pkg.
REQ-027 SHALL use one sub-module mac_pe (registered A/B pass-through, step enable, clear, saturate option), instanced DIM x DIM.
REQ-028 SHALL keep skew registers, FSM, beat/drain counters and read mux in systolic_engine.

Verification (DIM=4, BITS_AB=8, BITS_C=16)
REQ-029 SHALL cover: A=I, B[i][j]=4i+j, accumulate=0, in_valid held 1 -> done at cycle 11, rd_row r returns {4r,4r+1,4r+2,4r+3}.
REQ-030 SHALL cover: same job run twice, second with accumulate=1 -> every C[i][j]=2*(4i+j).
REQ-031 SHALL cover: A,B all 127 -> C all 32767 with SATURATE=1, all -1020 with SATURATE=0.
REQ-032 SHALL cover: 3-cycle in_valid gap after beat 1 -> results as REQ-029, done at cycle 14.
REQ-033 SHALL cover: rst pulsed mid-LOAD -> busy 0 next cycle, subsequent reads of every row return 0.
REQ-034 SHALL cover: start and rd_en during DRAIN -> no new job, rd_valid stays 0.
